mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the microcontroller's single-port program/data memory between three requesters: the debug/DIP loader, the load/store unit and the instruction-fetch unit. The arbiter serializes accesses, applies fixed priority with a fetch-starvation guard, and returns read data with a per-requester valid pulse. It sits between the CPU core (plus debug loader) and the memory macro, all in the `i_CLK` domain.

## Interface
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 16: memory word width.
- `RD_LAT`, 1: memory read latency in cycles, legal range 1..3.
- `STARVE_LIM`, 3: consecutive lost arbitrations after which fetch outranks data.

Ports:
- `i_CLK`  in  1  the only clock; all logic is rising-edge.
- `i_RST`  in  1  synchronous, active-high reset.
- `i_REQ_DBG`, `i_REQ_DATA`, `i_REQ_FETCH`  in  1 each  access requests.
- `i_WE_DBG`, `i_WE_DATA`  in  1 each  1 = write, 0 = read. Fetch is always a read.
- `i_ADDR_DBG`, `i_ADDR_DATA`, `i_ADDR_FETCH`  in  `ADDR_W` each  access addresses.
- `i_WDATA_DBG`, `i_WDATA_DATA`  in  `DATA_W` each  write data.
- `o_GNT_DBG`, `o_GNT_DATA`, `o_GNT_FETCH`  out  1 each  one-cycle pulse when the access is issued.
- `o_RVALID_DBG`, `o_RVALID_DATA`, `o_RVALID_FETCH`  out  1 each  one-cycle pulse when `o_RDATA` holds that requester's read data.
- `o_RDATA`  out  `DATA_W`  last captured read word.
- `o_MEM_EN`, `o_MEM_WE`  out  1 each  memory strobe and write enable.
- `o_MEM_ADDR`  out  `ADDR_W`  memory address.
- `o_MEM_WDATA`  out  `DATA_W`  memory write data.
- `i_MEM_RDATA`  in  `DATA_W`  memory read data.
- `o_BUSY`  out  1  1 when state ≠ IDLE.
- `o_OWNER`  out  2  current owner: 0 = none, 1 = DBG, 2 = DATA, 3 = FETCH.

## Operation
- **States.** The FSM has three states: IDLE, ACCESS, WAIT. Exactly one transaction is outstanding at a time.
- **IDLE.** If any request is high, pick a winner and go to ACCESS. At the same edge, latch the owner, WE, address and wdata.
- **ACCESS (one cycle).**
  - Drives `o_MEM_EN` = 1, `o_MEM_WE` = latched WE, and the latched address and wdata.
  - The winner's `o_GNT_*` is 1.
  - A write goes to IDLE next. A read goes to WAIT.
- **WAIT.** Lasts `RD_LAT` cycles. On the last one, register `i_MEM_RDATA` into `o_RDATA` and go to IDLE. In the next cycle, the owner's `o_RVALID_*` = 1.
- **Priority.** DBG > DATA > FETCH.
  - Exception: when the starvation counter equals `STARVE_LIM`, FETCH beats DATA. DBG always wins.
- **Starvation counter** (saturating, width sufficient for `STARVE_LIM`):
  - Increments at each IDLE→ACCESS where FETCH was requesting but lost.
  - Clears when FETCH is granted or when `i_REQ_FETCH` = 0 in IDLE.
- **Requester protocol.**
  - The requester holds REQ, WE, ADDR and WDATA stable until its GNT.
  - It may drop REQ in the GNT cycle or later. REQ still high after GNT is treated as a new request.
  - A REQ dropped before GNT causes no transaction.
- **Outputs outside ACCESS.**
  - `o_MEM_EN` = 0 and `o_MEM_WE` = 0.
  - `o_MEM_ADDR` and `o_MEM_WDATA` hold their last values.
- **`o_RDATA`** holds until the next read capture. Writes never change it.
- **Reset.** All outputs are 0: GNTs, RVALIDs, `o_RDATA`, memory strobes, address, wdata, `o_BUSY`, `o_OWNER`. State is IDLE and the starvation counter is 0.
  - Reset mid-transaction aborts it: no RVALID is issued. A write already strobed in ACCESS is not undone.

## Timing
- `i_REQ_x` is sampled high in IDLE cycle T. Then `o_GNT_x` and `o_MEM_EN` are high in cycle T+1.
- **Write:** the memory writes at the end of T+1, and the arbiter is IDLE in T+2. Minimum write interval is 2 cycles.
- **Read:** memory data is valid in cycle T+1+`RD_LAT` and captured at the end of that cycle. `o_RVALID_x` and `o_RDATA` are valid in T+2+`RD_LAT`.
  - The arbiter is IDLE in that same cycle, so a new grant can come at T+3+`RD_LAT`.
  - Read interval is `RD_LAT`+2 cycles.
- **Simultaneous requests:** one grant per arbitration. Losers remain pending.
- **RVALID overlap:** RVALID for the previous read can coincide with the next arbitration. RVALID never overlaps that requester's next GNT of the same transaction.

## Test plan
- **Reset.** Assert `i_RST` for 2 cycles mid-read (WAIT state). Required: all outputs 0 in the cycle after the edge, no RVALID afterwards, `o_OWNER` = 0.
- **Single read, `RD_LAT` = 1.** FETCH reads addr 0x10, memory returns 0xA55A. Required: GNT_FETCH at T+1; RVALID_FETCH with `o_RDATA` = 0xA55A at T+3.
- **Debug write then read.** DBG writes 0x0FE5 to 0x20, then reads 0x20. Required: `o_MEM_WE` = 1 only in the write's ACCESS cycle; the read returns 0x0FE5 with RVALID_DBG.
- **Priority.** DBG, DATA and FETCH request in the same cycle and stay asserted. Required grant order: DBG, DATA, FETCH.
- **Starvation guard, `STARVE_LIM` = 3.** DATA and FETCH both request reads continuously. Required: DATA is granted 3 times, then FETCH, then the pattern repeats. With DBG also requesting, DBG is granted first every time.
- **Dropped request.** DATA raises REQ for one cycle while a FETCH read is in WAIT. Required: no GNT_DATA and no memory access to DATA's address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the debug loader,
// the load/store unit and the instruction fetch unit. One transaction is in
// flight at a time; priority is DBG > DATA > FETCH, except that FETCH beats DATA
// once it has lost STARVE_LIM arbitrations in a row.
//
// Handshake: a requester holds REQ/WE/ADDR/WDATA stable until its one-cycle
// GNT pulse, which marks the cycle the access is strobed into the memory. For
// reads, a one-cycle RVALID pulse later marks the cycle o_RDATA holds that
// requester's word. REQ still high once the arbiter is back in IDLE is a new
// request.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_REQ_DBG,
  input  logic              i_REQ_DATA,
  input  logic              i_REQ_FETCH,
  input  logic              i_WE_DBG,
  input  logic              i_WE_DATA,
  input  logic [ADDR_W-1:0] i_ADDR_DBG,
  input  logic [ADDR_W-1:0] i_ADDR_DATA,
  input  logic [ADDR_W-1:0] i_ADDR_FETCH,
  input  logic [DATA_W-1:0] i_WDATA_DBG,
  input  logic [DATA_W-1:0] i_WDATA_DATA,
  output logic              o_GNT_DBG,
  output logic              o_GNT_DATA,
  output logic              o_GNT_FETCH,
  output logic              o_RVALID_DBG,
  output logic              o_RVALID_DATA,
  output logic              o_RVALID_FETCH,
  output logic [DATA_W-1:0] o_RDATA,
  output logic              o_MEM_EN,
  output logic              o_MEM_WE,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic [DATA_W-1:0] o_MEM_WDATA,
  input  logic [DATA_W-1:0] i_MEM_RDATA,
  output logic              o_BUSY,
  output logic [1:0]        o_OWNER
);

  localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);
  localparam logic [1:0]       WAIT_LAST  = 2'(RD_LAT - 1);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_DBG   = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;
  localparam logic [1:0] OWN_FETCH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve;
  logic [1:0]        r_wait_cnt;
  logic [1:0]        r_cur;
  logic              r_gnt_dbg, r_gnt_data, r_gnt_fetch;
  logic              r_rv_dbg, r_rv_data, r_rv_fetch;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;
  logic [1:0]        r_owner;

  logic              w_fetch_pri;
  logic [1:0]        w_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  assign w_fetch_pri = (r_starve == STARVE_MAX);

  // Pick the winner among current requests and mux its access attributes.
  always_comb begin
    w_win       = OWN_NONE;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    if (i_REQ_DBG) begin
      w_win = OWN_DBG;
    end else if (i_REQ_DATA && !(i_REQ_FETCH && w_fetch_pri)) begin
      w_win = OWN_DATA;
    end else if (i_REQ_FETCH) begin
      w_win = OWN_FETCH;
    end
    case (w_win)
      OWN_DBG: begin
        w_win_we    = i_WE_DBG;
        w_win_addr  = i_ADDR_DBG;
        w_win_wdata = i_WDATA_DBG;
      end
      OWN_DATA: begin
        w_win_we    = i_WE_DATA;
        w_win_addr  = i_ADDR_DATA;
        w_win_wdata = i_WDATA_DATA;
      end
      OWN_FETCH: begin
        w_win_addr  = i_ADDR_FETCH;
      end
      default: ;
    endcase
  end

  // Arbitration FSM with registered grant, strobe, read-return and status outputs.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= ST_IDLE;
      r_starve    <= '0;
      r_wait_cnt  <= '0;
      r_cur       <= OWN_NONE;
      r_gnt_dbg   <= 1'b0;
      r_gnt_data  <= 1'b0;
      r_gnt_fetch <= 1'b0;
      r_rv_dbg    <= 1'b0;
      r_rv_data   <= 1'b0;
      r_rv_fetch  <= 1'b0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_owner     <= OWN_NONE;
    end else begin
      r_gnt_dbg   <= 1'b0;
      r_gnt_data  <= 1'b0;
      r_gnt_fetch <= 1'b0;
      r_rv_dbg    <= 1'b0;
      r_rv_data   <= 1'b0;
      r_rv_fetch  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!i_REQ_FETCH || (w_win == OWN_FETCH)) begin
            r_starve <= '0;
          end else if (r_starve != STARVE_MAX) begin
            r_starve <= r_starve + CNT_W'(1);
          end
          if (w_win != OWN_NONE) begin
            r_state     <= ST_ACCESS;
            r_cur       <= w_win;
            r_owner     <= w_win;
            r_busy      <= 1'b1;
            r_gnt_dbg   <= (w_win == OWN_DBG);
            r_gnt_data  <= (w_win == OWN_DATA);
            r_gnt_fetch <= (w_win == OWN_FETCH);
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
          end
        end
        ST_ACCESS: begin
          // r_mem_we still holds the latched WE of the access in flight.
          if (r_mem_we) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_owner <= OWN_NONE;
          end else begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_rdata    <= i_MEM_RDATA;
            r_rv_dbg   <= (r_cur == OWN_DBG);
            r_rv_data  <= (r_cur == OWN_DATA);
            r_rv_fetch <= (r_cur == OWN_FETCH);
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_owner    <= OWN_NONE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign o_GNT_DBG      = r_gnt_dbg;
  assign o_GNT_DATA     = r_gnt_data;
  assign o_GNT_FETCH    = r_gnt_fetch;
  assign o_RVALID_DBG   = r_rv_dbg;
  assign o_RVALID_DATA  = r_rv_data;
  assign o_RVALID_FETCH = r_rv_fetch;
  assign o_RDATA        = r_rdata;
  assign o_MEM_EN       = r_mem_en;
  assign o_MEM_WE       = r_mem_we;
  assign o_MEM_ADDR     = r_mem_addr;
  assign o_MEM_WDATA    = r_mem_wdata;
  assign o_BUSY         = r_busy;
  assign o_OWNER        = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (RD_LAT = 1, STARVE_LIM = 3) with a behavioral
// single-port memory whose read data appears one cycle after the strobe.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        i_RST;
  logic        i_REQ_DBG, i_REQ_DATA, i_REQ_FETCH;
  logic        i_WE_DBG, i_WE_DATA;
  logic [7:0]  i_ADDR_DBG, i_ADDR_DATA, i_ADDR_FETCH;
  logic [15:0] i_WDATA_DBG, i_WDATA_DATA;
  logic        o_GNT_DBG, o_GNT_DATA, o_GNT_FETCH;
  logic        o_RVALID_DBG, o_RVALID_DATA, o_RVALID_FETCH;
  logic [15:0] o_RDATA;
  logic        o_MEM_EN, o_MEM_WE;
  logic [7:0]  o_MEM_ADDR;
  logic [15:0] o_MEM_WDATA;
  logic [15:0] i_MEM_RDATA;
  logic        o_BUSY;
  logic [1:0]  o_OWNER;

  // clock / reset block
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .STARVE_LIM(3)) dut (
    .i_CLK(clk), .i_RST(i_RST),
    .i_REQ_DBG(i_REQ_DBG), .i_REQ_DATA(i_REQ_DATA), .i_REQ_FETCH(i_REQ_FETCH),
    .i_WE_DBG(i_WE_DBG), .i_WE_DATA(i_WE_DATA),
    .i_ADDR_DBG(i_ADDR_DBG), .i_ADDR_DATA(i_ADDR_DATA), .i_ADDR_FETCH(i_ADDR_FETCH),
    .i_WDATA_DBG(i_WDATA_DBG), .i_WDATA_DATA(i_WDATA_DATA),
    .o_GNT_DBG(o_GNT_DBG), .o_GNT_DATA(o_GNT_DATA), .o_GNT_FETCH(o_GNT_FETCH),
    .o_RVALID_DBG(o_RVALID_DBG), .o_RVALID_DATA(o_RVALID_DATA), .o_RVALID_FETCH(o_RVALID_FETCH),
    .o_RDATA(o_RDATA), .o_MEM_EN(o_MEM_EN), .o_MEM_WE(o_MEM_WE),
    .o_MEM_ADDR(o_MEM_ADDR), .o_MEM_WDATA(o_MEM_WDATA), .i_MEM_RDATA(i_MEM_RDATA),
    .o_BUSY(o_BUSY), .o_OWNER(o_OWNER)
  );

  // memory macro: contents start from pat(), read data one cycle after strobe
  logic [15:0] mem   [256];
  logic [15:0] model [256];
  logic [15:0] rd_q;
  logic        mem_init_done = 1'b0;
  assign i_MEM_RDATA = rd_q;

  function automatic logic [15:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (b == 8'h10) return 16'hA55A;
    return {~b, b};
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] = pat(i);
      mem_init_done = 1'b1;
    end
    if (o_MEM_EN === 1'b1) begin
      if (o_MEM_WE === 1'b1) mem[o_MEM_ADDR] = o_MEM_WDATA;
      else rd_q <= mem[o_MEM_ADDR];
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [26:0] gnt_q[$];   // {owner, we, addr, wdata}
  logic [17:0] exp_q[$];   // {owner, rdata}
  logic [15:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h, expected no such event", name, act);
  endtask

  function automatic logic [1:0] enc(input logic [2:0] v);
    case (v)
      3'b100:  return 2'd1;
      3'b010:  return 2'd2;
      3'b001:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic expect_txn(input logic [1:0] who, input logic we, input logic [7:0] addr,
                            input logic [15:0] wd, input logic [15:0] rd);
    gnt_q.push_back({who, we, addr, wd});
    if (!we) exp_q.push_back({who, rd});
  endtask

  // monitor: grants and read returns are popped from the expected queues
  always @(negedge clk) begin : mon
    logic [2:0]  g;
    logic [2:0]  v;
    logic [26:0] eg;
    logic [17:0] er;
    g = {o_GNT_DBG === 1'b1, o_GNT_DATA === 1'b1, o_GNT_FETCH === 1'b1};
    v = {o_RVALID_DBG === 1'b1, o_RVALID_DATA === 1'b1, o_RVALID_FETCH === 1'b1};
    if (g != 3'b000) begin
      if (gnt_q.size() == 0) begin
        fail_now("unexpected_gnt", {29'd0, g});
      end else begin
        eg = gnt_q.pop_front();
        check("gnt_owner", {30'd0, enc(g)}, {30'd0, eg[26:25]});
        check("gnt_o_owner", {30'd0, o_OWNER}, {30'd0, eg[26:25]});
        check("gnt_mem_en", {31'd0, o_MEM_EN}, 32'd1);
        check("gnt_mem_we", {31'd0, o_MEM_WE}, {31'd0, eg[24]});
        check("gnt_mem_addr", {24'd0, o_MEM_ADDR}, {24'd0, eg[23:16]});
        if (eg[24]) check("gnt_mem_wdata", {16'd0, o_MEM_WDATA}, {16'd0, eg[15:0]});
      end
    end else if (o_MEM_EN === 1'b1 || o_MEM_WE === 1'b1) begin
      fail_now("strobe_without_gnt", {30'd0, o_MEM_EN, o_MEM_WE});
    end
    if (v != 3'b000) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rvalid", {29'd0, v});
      end else begin
        er = exp_q.pop_front();
        check("rvalid_owner", {30'd0, enc(v)}, {30'd0, er[17:16]});
        check("rdata", {16'd0, o_RDATA}, {16'd0, er[15:0]});
      end
    end
  end

  // driver tasks
  task automatic set_req(input int who, input logic req, input logic we,
                         input logic [7:0] addr, input logic [15:0] wd);
    case (who)
      1: begin i_REQ_DBG = req; i_WE_DBG = we; i_ADDR_DBG = addr; i_WDATA_DBG = wd; end
      2: begin i_REQ_DATA = req; i_WE_DATA = we; i_ADDR_DATA = addr; i_WDATA_DATA = wd; end
      3: begin i_REQ_FETCH = req; i_ADDR_FETCH = addr; end
      default: ;
    endcase
  endtask

  function automatic logic gnt_of(input int who);
    case (who)
      1:       return o_GNT_DBG === 1'b1;
      2:       return o_GNT_DATA === 1'b1;
      3:       return o_GNT_FETCH === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_gnt(input int who, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (gnt_of(who)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("gnt_timeout", who);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_BUSY === 1'b0 && exp_q.size() == 0 && gnt_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("idle_timeout", {16'(gnt_q.size()), 16'(exp_q.size())});
  endtask

  // hold REQ high for n consecutive grants, then drop it
  task automatic run_req(input int who, input int n, input logic [7:0] addr);
    bit ok;
    @(posedge clk); #1;
    set_req(who, 1'b1, 1'b0, addr, 16'h0);
    for (int k = 0; k < n; k++) begin
      wait_gnt(who, ok);
      if (!ok) break;
    end
    @(posedge clk); #1;
    set_req(who, 1'b0, 1'b0, addr, 16'h0);
  endtask

  typedef struct {
    logic [1:0]  who;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  task automatic do_txn(input vec_t t);
    bit ok;
    @(posedge clk); #1;
    expect_txn(t.who, t.we, t.addr, t.wd, t.exp);
    if (t.we) model[t.addr] = t.wd;
    set_req(int'(t.who), 1'b1, t.we, t.addr, t.wd);
    wait_gnt(int'(t.who), ok);
    @(posedge clk); #1;
    set_req(int'(t.who), 1'b0, 1'b0, 8'h0, 16'h0);
    wait_idle();
    if (t.we) check("rdata_hold_after_write", {16'd0, o_RDATA}, {16'd0, last_rd});
    else last_rd = t.exp;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_gnt"}, {29'd0, o_GNT_DBG, o_GNT_DATA, o_GNT_FETCH}, 32'd0);
    check({tag, "_rvalid"}, {29'd0, o_RVALID_DBG, o_RVALID_DATA, o_RVALID_FETCH}, 32'd0);
    check({tag, "_rdata"}, {16'd0, o_RDATA}, 32'd0);
    check({tag, "_mem_strobe"}, {30'd0, o_MEM_EN, o_MEM_WE}, 32'd0);
    check({tag, "_mem_addr"}, {24'd0, o_MEM_ADDR}, 32'd0);
    check({tag, "_mem_wdata"}, {16'd0, o_MEM_WDATA}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_BUSY}, 32'd0);
    check({tag, "_owner"}, {30'd0, o_OWNER}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0]  = '{2'd3, 1'b0, 8'h10, 16'h0000, 16'hA55A};
    vecs[1]  = '{2'd1, 1'b1, 8'h20, 16'h0FE5, 16'h0000};
    vecs[2]  = '{2'd1, 1'b0, 8'h20, 16'h0000, 16'h0FE5};
    vecs[3]  = '{2'd2, 1'b1, 8'h30, 16'h1234, 16'h0000};
    vecs[4]  = '{2'd2, 1'b0, 8'h30, 16'h0000, 16'h1234};
    vecs[5]  = '{2'd3, 1'b0, 8'h30, 16'h0000, 16'h1234};
    vecs[6]  = '{2'd2, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
    vecs[7]  = '{2'd3, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
    vecs[8]  = '{2'd1, 1'b1, 8'h00, 16'h0000, 16'h0000};
    vecs[9]  = '{2'd2, 1'b0, 8'h00, 16'h0000, 16'h0000};
    vecs[10] = '{2'd2, 1'b0, 8'h10, 16'h0000, 16'hA55A};
    for (int i = 0; i < 256; i++) model[i] = pat(i);
    last_rd = 16'h0;

    i_RST = 1'b1;
    for (int w = 1; w <= 3; w++) set_req(w, 1'b0, 1'b0, 8'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1 i_RST = 1'b0;
    @(negedge clk);
    check_reset_outs("reset");

    // single FETCH read: GNT at T+1, RVALID with data at T+3
    @(posedge clk); #1;
    expect_txn(2'd3, 1'b0, 8'h10, 16'h0, 16'hA55A);
    set_req(3, 1'b1, 1'b0, 8'h10, 16'h0);
    @(negedge clk);
    check("rd_gnt_at_T", {31'd0, o_GNT_FETCH}, 32'd0);
    @(negedge clk);
    check("rd_gnt_at_T1", {31'd0, o_GNT_FETCH}, 32'd1);
    @(posedge clk); #1;
    set_req(3, 1'b0, 1'b0, 8'h0, 16'h0);
    @(negedge clk);
    check("rd_rvalid_at_T2", {31'd0, o_RVALID_FETCH}, 32'd0);
    check("rd_busy_at_T2", {31'd0, o_BUSY}, 32'd1);
    @(negedge clk);
    check("rd_rvalid_at_T3", {31'd0, o_RVALID_FETCH}, 32'd1);
    check("rd_rdata_at_T3", {16'd0, o_RDATA}, 32'h0000_A55A);
    check("rd_idle_at_T3", {31'd0, o_BUSY}, 32'd0);
    last_rd = 16'hA55A;

    // DBG write: WE only in the ACCESS cycle, address holds afterwards
    @(posedge clk); #1;
    expect_txn(2'd1, 1'b1, 8'h50, 16'hBEEF, 16'h0);
    model[8'h50] = 16'hBEEF;
    set_req(1, 1'b1, 1'b1, 8'h50, 16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    check("wr_we_at_T1", {31'd0, o_MEM_WE}, 32'd1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 8'h0, 16'h0);
    @(negedge clk);
    check("wr_strobe_at_T2", {30'd0, o_MEM_EN, o_MEM_WE}, 32'd0);
    check("wr_addr_hold", {24'd0, o_MEM_ADDR}, 32'h50);
    check("wr_wdata_hold", {16'd0, o_MEM_WDATA}, 32'h0000_BEEF);
    check("wr_idle_at_T2", {31'd0, o_BUSY}, 32'd0);
    check("wr_rdata_kept", {16'd0, o_RDATA}, {16'd0, last_rd});
    wait_idle();

    // table-driven single transactions
    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    // priority: all three request together, each wants one grant
    expect_txn(2'd1, 1'b0, 8'h01, 16'h0, model[8'h01]);
    expect_txn(2'd2, 1'b0, 8'h02, 16'h0, model[8'h02]);
    expect_txn(2'd3, 1'b0, 8'h03, 16'h0, model[8'h03]);
    fork
      run_req(1, 1, 8'h01);
      run_req(2, 1, 8'h02);
      run_req(3, 1, 8'h03);
    join
    wait_idle();

    // starvation guard: DATA x3, FETCH, DATA x3, FETCH
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) expect_txn(2'd2, 1'b0, 8'h04, 16'h0, model[8'h04]);
      expect_txn(2'd3, 1'b0, 8'h05, 16'h0, model[8'h05]);
    end
    fork
      run_req(2, 6, 8'h04);
      run_req(3, 2, 8'h05);
    join
    wait_idle();

    // DBG still wins over a starved FETCH
    expect_txn(2'd1, 1'b0, 8'h06, 16'h0, model[8'h06]);
    expect_txn(2'd1, 1'b0, 8'h06, 16'h0, model[8'h06]);
    expect_txn(2'd2, 1'b0, 8'h07, 16'h0, model[8'h07]);
    expect_txn(2'd3, 1'b0, 8'h08, 16'h0, model[8'h08]);
    for (int j = 0; j < 3; j++) expect_txn(2'd2, 1'b0, 8'h07, 16'h0, model[8'h07]);
    fork
      run_req(1, 2, 8'h06);
      run_req(2, 4, 8'h07);
      run_req(3, 1, 8'h08);
    join
    wait_idle();

    // dropped request: DATA pulses REQ for one cycle while FETCH is in WAIT
    @(posedge clk); #1;
    expect_txn(2'd3, 1'b0, 8'h09, 16'h0, model[8'h09]);
    set_req(3, 1'b1, 1'b0, 8'h09, 16'h0);
    wait_gnt(3, ok);
    @(posedge clk); #1;
    set_req(3, 1'b0, 1'b0, 8'h0, 16'h0);
    set_req(2, 1'b1, 1'b0, 8'h0A, 16'h0);
    @(posedge clk); #1;
    set_req(2, 1'b0, 1'b0, 8'h0, 16'h0);
    repeat (6) @(negedge clk);
    check("drop_mem_addr", {24'd0, o_MEM_ADDR}, 32'h09);
    wait_idle();

    // reset during WAIT aborts the read
    @(posedge clk); #1;
    gnt_q.push_back({2'd3, 1'b0, 8'h11, 16'h0});
    set_req(3, 1'b1, 1'b0, 8'h11, 16'h0);
    wait_gnt(3, ok);
    @(posedge clk); #1;
    i_RST = 1'b1;
    set_req(3, 1'b0, 1'b0, 8'h0, 16'h0);
    @(negedge clk);
    check("mid_reset_in_wait", {31'd0, o_BUSY}, 32'd1);
    @(negedge clk);
    check_reset_outs("mid_reset");
    @(posedge clk); #1;
    i_RST = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_busy", {31'd0, o_BUSY}, 32'd0);
    check("post_reset_rdata", {16'd0, o_RDATA}, 32'd0);
    check("post_reset_owner", {30'd0, o_OWNER}, 32'd0);

    check("gnt_q_left", gnt_q.size(), 32'd0);
    check("exp_q_left", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
